cic_interpolator: RTL

- N-stage CIC interpolator with integer rate change R: comb section at the input rate, zero-stuff upsampler, integrator section at the output rate, then power-of-two gain compensation with saturation.
- Sits on the transmit/upsampling side of the DFE filter array. It is the opposite rate direction of the decimating CIC chain.
- Accepts one sample per R cycles through a valid/ready handshake. Emits one sample per update cycle.

---
 rtl/cic_interpolator_if.sv | 31 +++
 rtl/cic_interpolator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cic_interpolator_if.sv
// Sample stream bundle for the CIC interpolator: an input valid/ready
// handshake and an output valid strobe with its data.
interface cic_interpolator_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out;

  // Upstream source / downstream sink side
  modport master (
    output in_valid,
    output in,
    input  in_ready,
    input  out_valid,
    input  out
  );

  // Interpolator side
  modport slave (
    input  in_valid,
    input  in,
    output in_ready,
    output out_valid,
    output out
  );

endinterface

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator by R.
// The comb section runs once per accepted input sample. The sample is
// zero-stuffed into R output slots. The integrator section runs on every
// update cycle. The result is scaled by an arithmetic right shift, with
// saturation to the sample width.
module cic_interpolator #(
  parameter int DATA_WIDTH = 16,
  parameter int R          = 4,
  parameter int N          = 3,
  parameter int M          = 1,
  parameter int ACC_WIDTH  = DATA_WIDTH + N * $clog2(R * M),
  parameter int GAIN_SHIFT = N * $clog2(R * M) - $clog2(R)
) (
  input  logic                clk,
  input  logic                rst_n,
  cic_interpolator_if.slave   bus
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  // Saturation bounds, sign-extended to the accumulator width
  localparam acc_t SAT_MAX = {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic [PW-1:0]                phase_q, phase_d;
  acc_t                         dly_q [N][M];
  acc_t                         acc_q [N];
  logic signed [DATA_WIDTH-1:0] out_q;
  logic                         out_valid_q;

  logic                         accept;
  logic                         update;
  acc_t                         comb [N+1];
  acc_t                         x;
  acc_t                         shifted;
  logic signed [DATA_WIDTH-1:0] sat_val;

  // in_ready depends only on the phase register, never on in_valid
  assign bus.in_ready  = (phase_q == '0);
  assign accept        = bus.in_ready && bus.in_valid;
  assign update        = accept || (phase_q != '0);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

  // Comb chain and zero-stuffed integrator input
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    x       = '0;
    comb[0] = acc_t'(bus.in);
    for (int k = 1; k <= N; k++) begin
      comb[k] = comb[k-1] - dly_q[k-1][M-1];
    end
    if (accept) begin
      x = comb[N];
    end
  end

  // Scale by the gain shift (floor rounding), then clamp to the sample range
  always_comb begin
    shifted = acc_q[N-1] >>> GAIN_SHIFT;
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Next phase: restart at 1 on accept, count through R-1, then wrap to 0
  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      phase_d = PW'(1);
    end else if (phase_q != '0) begin
      phase_d = (phase_q == PW'(R - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  // Phase counter and output strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      out_valid_q <= update;
    end
  end

  // Comb delay lines advance only when a new input sample is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay-line array is cleared explicitly. Reset must discard
      // all history, so this storage cannot be left to its power-up contents.
      for (int k = 0; k < N; k++) begin
        for (int j = 0; j < M; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        dly_q[k][0] <= comb[k];
        for (int j = 1; j < M; j++) begin
          dly_q[k][j] <= dly_q[k][j-1];
        end
      end
    end
  end

  // Integrator cascade and output register, advanced on every update cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
      end
      out_q <= '0;
    end else if (update) begin
      // NOTE: non-blocking assignments make each stage add the previous
      // stage's pre-update value, giving one register of delay per stage.
      acc_q[0] <= acc_q[0] + x;
      for (int k = 1; k < N; k++) begin
        acc_q[k] <= acc_q[k] + acc_q[k-1];
      end
      out_q <= sat_val;
    end
  end

endmodule
